// File: rtl/bombe_position_sequencer.sv
// bombe_position_sequencer: odometer sweep of the three rotor letters AAA..ZZZ.
// Each position is loaded, left to settle, then tested; a hit stops the sweep.
module bombe_position_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_resume,
  input  logic        i_test_ack,
  input  logic        i_test_hit,
  output logic [7:0]  o_pos_left,
  output logic [7:0]  o_pos_mid,
  output logic [7:0]  o_pos_right,
  output logic        o_load_pos,
  output logic        o_test_req,
  output logic        o_busy,
  output logic        o_found,
  output logic        o_done,
  output logic [14:0] o_test_count
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, TEST, STEP, FOUND, DONE} state_t;
  localparam logic [7:0] A = 8'h41;
  localparam logic [7:0] Z = 8'h5A;
  localparam logic [14:0] MAX_COUNT = 15'd17576;
  state_t r_state, w_next;
  logic [3:0] r_cnt, w_cnt;
  logic [7:0] r_left, r_mid, r_right, w_left, w_mid, w_right;
  logic [14:0] r_count, w_count;
  logic r_load_pos, r_test_req, r_busy, r_found, r_done;
  logic w_zzz;
  assign w_zzz = (r_left == Z) && (r_mid == Z) && (r_right == Z);
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt;
    w_left = r_left;
    w_mid = r_mid;
    w_right = r_right;
    w_count = r_count;
    case (r_state)
      IDLE, FOUND, DONE:
        if (i_start) begin
          w_next = LOAD;
          w_left = A;
          w_mid = A;
          w_right = A;
          w_count = '0;
        end else if (r_state == FOUND && i_resume) begin
          w_next = STEP;
        end
      LOAD: begin
        w_next = SETTLE;
        w_cnt = 4'(SETTLE_CYCLES - 1);
      end
      SETTLE: begin
        w_next = (r_cnt == 4'd0) ? TEST : SETTLE;
        w_cnt = (r_cnt == 4'd0) ? r_cnt : r_cnt - 4'd1;
      end
      TEST:
        if (i_test_ack) begin
          w_count = (r_count == MAX_COUNT) ? r_count : r_count + 15'd1;
          w_next = i_test_hit ? FOUND : STEP;
        end
      STEP: begin
        w_next = w_zzz ? DONE : LOAD;
        // odometer carry: right wraps into mid, mid wraps into left
        w_right = w_zzz ? r_right : (r_right == Z) ? A : r_right + 8'd1;
        w_mid = (w_zzz || r_right != Z) ? r_mid : (r_mid == Z) ? A : r_mid + 8'd1;
        w_left = (w_zzz || r_right != Z || r_mid != Z) ? r_left : r_left + 8'd1;
      end
      default: w_next = IDLE;
    endcase
    if (i_abort) begin
      w_next = IDLE;
      w_cnt = '0;
      w_left = A;
      w_mid = A;
      w_right = A;
      w_count = '0;
    end
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_left <= A;
      r_mid <= A;
      r_right <= A;
      r_count <= '0;
      r_load_pos <= 1'b0;
      r_test_req <= 1'b0;
      r_busy <= 1'b0;
      r_found <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_left <= w_left;
      r_mid <= w_mid;
      r_right <= w_right;
      r_count <= w_count;
      r_load_pos <= (w_next == LOAD);
      r_test_req <= (w_next == TEST);
      r_busy <= (w_next == LOAD) || (w_next == SETTLE) || (w_next == TEST) || (w_next == STEP);
      r_found <= (w_next == FOUND);
      r_done <= (w_next == DONE);
    end
  end
  assign o_pos_left = r_left;
  assign o_pos_mid = r_mid;
  assign o_pos_right = r_right;
  assign o_load_pos = r_load_pos;
  assign o_test_req = r_test_req;
  assign o_busy = r_busy;
  assign o_found = r_found;
  assign o_done = r_done;
  assign o_test_count = r_count;
endmodule

// File: tb/tb_bombe_position_sequencer.sv
// tb_bombe_position_sequencer: directed/randomised checks of the rotor sweep sequencer.
module tb_bombe_position_sequencer;
  localparam int S = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0, resume = 1'b0, ack = 1'b0, hit = 1'b0;
  logic [7:0] pl, pm, pr;
  logic load, req, busy, found, done;
  logic [14:0] cnt;
  logic s_start = 1'b0;
  logic [7:0] s_pl, s_pm, s_pr;
  logic s_load, s_req, s_busy, s_found, s_done;
  logic [14:0] s_cnt;
  int errors = 0, checks = 0, n_loads = 0, bad_loads = 0;

  bombe_position_sequencer #(.SETTLE_CYCLES(S)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort), .i_resume(resume),
    .i_test_ack(ack), .i_test_hit(hit), .o_pos_left(pl), .o_pos_mid(pm), .o_pos_right(pr),
    .o_load_pos(load), .o_test_req(req), .o_busy(busy), .o_found(found), .o_done(done),
    .o_test_count(cnt));

  // short settle keeps the exhaustive sweep within the cycle budget
  bombe_position_sequencer #(.SETTLE_CYCLES(1)) sweep (
    .i_clock(clk), .i_reset(rst), .i_start(s_start), .i_abort(1'b0), .i_resume(1'b0),
    .i_test_ack(1'b1), .i_test_hit(1'b0), .o_pos_left(s_pl), .o_pos_mid(s_pm), .o_pos_right(s_pr),
    .o_load_pos(s_load), .o_test_req(s_req), .o_busy(s_busy), .o_found(s_found), .o_done(s_done),
    .o_test_count(s_cnt));

  function automatic logic [23:0] pos_of(input int p);
    return {8'(8'h41 + p / 676), 8'(8'h41 + (p / 26) % 26), 8'(8'h41 + p % 26)};
  endfunction

  always @(negedge clk)
    if (s_load === 1'b1) begin
      if ({s_pl, s_pm, s_pr} !== pos_of(n_loads)) bad_loads++;
      n_loads++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load(input string tag);
    int n = 0;
    do begin tick(); n++; end while (load !== 1'b1 && n < 20);
    chk(tag, 32'(load), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    do begin tick(); n++; end while (req !== 1'b1 && n < 40);
    chk(tag, 32'(req), 32'd1);
  endtask

  initial begin
    int n, d;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_pos", 32'({pl, pm, pr}), 32'h414141);
    chk("rst_load", 32'(load), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_found", 32'(found), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(cnt), 0);
    start = 1'b1;
    s_start = 1'b1;
    tick();
    start = 1'b0;
    s_start = 1'b0;
    chk("start_load", 32'(load), 1);
    chk("start_pos", 32'({pl, pm, pr}), 32'(pos_of(0)));
    chk("start_busy", 32'(busy), 1);
    n = 0;
    do begin tick(); n++; end while (req !== 1'b1 && n < 40);
    chk("req_latency", 32'(n), 32'(S + 1));
    for (int p = 0; p <= 57; p++) begin
      chk("pos_in_test", 32'({pl, pm, pr}), 32'(pos_of(p)));
      chk("count_in_test", 32'(cnt), 32'(p));
      d = $urandom_range(0, 3);
      repeat (d) begin
        tick();
        chk("req_held", 32'(req), 1);
      end
      ack = 1'b1;
      hit = (p == 57);
      tick();
      ack = 1'b0;
      hit = 1'b0;
      if (p < 57) begin
        chk("req_drop", 32'(req), 0);
        wait_load("load_seen");
        chk("pos_next", 32'({pl, pm, pr}), 32'(pos_of(p + 1)));
        wait_req("req_seen");
      end
    end
    chk("hit_found", 32'(found), 1);
    chk("hit_busy", 32'(busy), 0);
    chk("hit_req", 32'(req), 0);
    chk("hit_count", 32'(cnt), 58);
    chk("hit_pos", 32'({pl, pm, pr}), 32'h414346);
    repeat (3) tick();
    chk("found_hold", 32'(found), 1);
    chk("found_pos_hold", 32'({pl, pm, pr}), 32'h414346);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_busy", 32'(busy), 1);
    chk("resume_found", 32'(found), 0);
    wait_load("resume_load");
    chk("resume_pos", 32'({pl, pm, pr}), 32'h414347);
    chk("resume_count", 32'(cnt), 58);
    wait_req("resume_req");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("slow_ack_req", 32'(req), 1);
      chk("slow_ack_count", 32'(cnt), 58);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("slow_ack_drop", 32'(req), 0);
    chk("slow_ack_count_inc", 32'(cnt), 59);
    wait_load("ign_load");
    chk("ign_pos", 32'({pl, pm, pr}), 32'(pos_of(59)));
    ack = 1'b1;
    hit = 1'b1;
    tick();
    tick();
    ack = 1'b0;
    hit = 1'b0;
    wait_req("ign_req");
    chk("ign_count", 32'(cnt), 59);
    chk("ign_found", 32'(found), 0);
    chk("ign_pos_test", 32'({pl, pm, pr}), 32'(pos_of(59)));
    tick();
    chk("ign_req_held", 32'(req), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_test_pos", 32'({pl, pm, pr}), 32'h414141);
    chk("abort_test_req", 32'(req), 0);
    chk("abort_test_busy", 32'(busy), 0);
    chk("abort_test_count", 32'(cnt), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_load", 32'(load), 1);
    tick();
    chk("settle_busy", 32'(busy), 1);
    chk("settle_load", 32'(load), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_settle_busy", 32'(busy), 0);
    chk("abort_settle_req", 32'(req), 0);
    chk("abort_settle_pos", 32'({pl, pm, pr}), 32'h414141);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_over_start", 32'(busy), 0);
    chk("abort_over_start_load", 32'(load), 0);
    n = 0;
    while (s_done !== 1'b1 && n < 90000) begin tick(); n++; end
    chk("sweep_done", 32'(s_done), 1);
    chk("sweep_pos", 32'({s_pl, s_pm, s_pr}), 32'h5A5A5A);
    chk("sweep_count", 32'(s_cnt), 17576);
    chk("sweep_loads", 32'(n_loads), 17576);
    chk("sweep_order", 32'(bad_loads), 0);
    chk("sweep_idle_req", 32'(s_req), 0);
    chk("sweep_idle_busy", 32'(s_busy), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
